// File: rtl/elevator_status_encoder_if.sv
// rtl/elevator_status_encoder_if.sv - elevator status inputs and display code outputs
interface elevator_status_encoder_if;
   logic [2:0] floor;
   logic       moving_up;
   logic       moving_dn;
   logic       door_open;
   logic [3:0] BCD;
   logic       code_chg;

   modport master (
      output floor, moving_up, moving_dn, door_open,
      input  BCD, code_chg
   );

   modport slave (
      input  floor, moving_up, moving_dn, door_open,
      output BCD, code_chg
   );
endinterface

// File: rtl/elevator_status_encoder.sv
// rtl/elevator_status_encoder.sv - elevator status to time-multiplexed 4-bit display code
module elevator_status_encoder #(
   parameter int DWELL = 50_000_000,
   parameter int CW    = 26
) (
   input  logic                      clk,
   input  logic                      rst_n,
   elevator_status_encoder_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_FAULT, S_ALT, S_ONESHOT} state_t;
   typedef enum logic [2:0] {M_IDLE, M_FAULT, M_UP, M_DN, M_OPEN, M_CLOSED, M_ARRIVE} mode_t;

   localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

   state_t        r_state, w_state_nxt;
   mode_t         r_mode, w_mode_nxt, w_mode_req;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_phase, w_phase_nxt;
   logic [3:0]    r_bcd, w_bcd_nxt;
   logic          r_code_chg;
   logic          r_prev_door, r_prev_move;
   logic          w_move, w_floor_ok;

   function automatic state_t state_of(input mode_t m);
      case (m)
         M_FAULT:                  return S_FAULT;
         M_UP, M_DN, M_OPEN:       return S_ALT;
         M_CLOSED, M_ARRIVE:       return S_ONESHOT;
         default:                  return S_IDLE;
      endcase
   endfunction

   function automatic logic [3:0] symbol_of(input mode_t m);
      case (m)
         M_UP:     return 4'd5;
         M_DN:     return 4'd8;
         M_OPEN:   return 4'd6;
         M_CLOSED: return 4'd7;
         M_ARRIVE: return 4'd9;
         default:  return 4'd0;
      endcase
   endfunction

   assign w_move     = bus.moving_up | bus.moving_dn;
   assign w_floor_ok = (bus.floor >= 3'd1) && (bus.floor <= 3'd4);

   always_comb begin
      w_mode_req = M_IDLE;
      if ((bus.moving_up & bus.moving_dn) | ~w_floor_ok)
         w_mode_req = M_FAULT;
      else if (bus.moving_up)
         w_mode_req = M_UP;
      else if (bus.moving_dn)
         w_mode_req = M_DN;
      else if (bus.door_open)
         w_mode_req = M_OPEN;
      else if (r_prev_door)
         w_mode_req = M_CLOSED;
      else if (r_prev_move)
         w_mode_req = M_ARRIVE;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_cnt_nxt   = r_cnt;
      w_phase_nxt = r_phase;
      // A one-shot keeps running until its dwell expires unless a real mode request arrives
      if (w_mode_req == M_IDLE && r_state == S_ONESHOT) begin
         if (r_cnt == CNT_MAX) begin
            w_state_nxt = S_IDLE;
            w_mode_nxt  = M_IDLE;
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b0;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end else if (w_mode_req != r_mode) begin
         w_state_nxt = state_of(w_mode_req);
         w_mode_nxt  = w_mode_req;
         w_cnt_nxt   = '0;
         w_phase_nxt = 1'b0;
      end else if (r_state == S_ALT) begin
         if (r_cnt == CNT_MAX) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = ~r_phase;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end

      case (w_state_nxt)
         S_IDLE:    w_bcd_nxt = {1'b0, bus.floor};
         S_ALT:     w_bcd_nxt = w_phase_nxt ? {1'b0, bus.floor} : symbol_of(w_mode_nxt);
         S_ONESHOT: w_bcd_nxt = symbol_of(w_mode_nxt);
         default:   w_bcd_nxt = 4'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mode      <= M_IDLE;
         r_cnt       <= '0;
         r_phase     <= 1'b0;
         r_bcd       <= 4'd0;
         r_code_chg  <= 1'b0;
         r_prev_door <= 1'b0;
         r_prev_move <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode      <= w_mode_nxt;
         r_cnt       <= w_cnt_nxt;
         r_phase     <= w_phase_nxt;
         r_bcd       <= w_bcd_nxt;
         r_code_chg  <= (w_bcd_nxt != r_bcd);
         r_prev_door <= bus.door_open;
         r_prev_move <= w_move;
      end
   end

   assign bus.BCD      = r_bcd;
   assign bus.code_chg = r_code_chg;

endmodule

// File: tb/tb_elevator_status_encoder.sv
// tb/tb_elevator_status_encoder.sv - bench for elevator_status_encoder with DWELL=4
module tb_elevator_status_encoder;

   logic clk;
   logic rst_n;

   elevator_status_encoder_if bus ();

   elevator_status_encoder #(.DWELL(4), .CW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] f;
      logic       u;
      logic       d;
      logic       o;
      logic [3:0] b;
      logic       c;
   } vec_t;

   typedef struct {
      logic [3:0] b;
      logic       c;
      int         id;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   vec_id = 0;

   function automatic void add(input logic [2:0] f, input logic u, input logic d, input logic o,
                               input logic [3:0] b, input logic c);
      vec_t v;
      v.f = f; v.u = u; v.d = d; v.o = o; v.b = b; v.c = c;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s vec %0d: got %0d, expected %0d", name, id, act, req);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input vec_t v);
      exp_t e;
      bus.floor     = v.f;
      bus.moving_up = v.u;
      bus.moving_dn = v.d;
      bus.door_open = v.o;
      e.b = v.b; e.c = v.c; e.id = vec_id;
      exp_q.push_back(e);
      vec_id++;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL scoreboard empty at vec %0d", vec_id);
      end else begin
         e = exp_q.pop_front();
         check("bcd", e.id, bus.BCD, e.b);
         check("code_chg", e.id, {3'b0, bus.code_chg}, {3'b0, e.c});
      end
      @(negedge clk);
   endtask

   task automatic stepv(input logic [2:0] f, input logic u, input logic d, input logic o,
                        input logic [3:0] b, input logic c);
      vec_t v;
      v.f = f; v.u = u; v.d = d; v.o = o; v.b = b; v.c = c;
      step(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // idle at floor 2
      add(2,0,0,0, 2,1); add(2,0,0,0, 2,0); add(2,0,0,0, 2,0);
      // moving up: 4-cycle symbol/floor alternation, floor change mid floor-phase
      add(3,1,0,0, 5,1); add(3,1,0,0, 5,0); add(3,1,0,0, 5,0); add(3,1,0,0, 5,0);
      add(3,1,0,0, 3,1); add(4,1,0,0, 4,1); add(4,1,0,0, 4,0); add(4,1,0,0, 4,0);
      add(4,1,0,0, 5,1);
      // door rises as motion stops: open wins, then close one-shot
      add(4,0,0,1, 6,1); add(4,0,0,1, 6,0);
      add(4,0,0,0, 7,1); add(4,0,0,0, 7,0); add(4,0,0,0, 7,0); add(4,0,0,0, 7,0);
      add(4,0,0,0, 4,1); add(4,0,0,0, 4,0);
      // moving down then arrival at floor 1
      add(1,0,1,0, 8,1); add(1,0,1,0, 8,0);
      add(1,0,0,0, 9,1); add(1,0,0,0, 9,0); add(1,0,0,0, 9,0); add(1,0,0,0, 9,0);
      add(1,0,0,0, 1,1);
      // arrival aborted by door opening
      add(1,0,1,0, 8,1); add(1,0,0,0, 9,1); add(1,0,0,1, 6,1); add(1,0,0,1, 6,0);
      // door falls as motion rises: up wins, no closed symbol
      add(1,1,0,0, 5,1); add(1,1,0,0, 5,0);
      add(1,0,0,0, 9,1); add(1,0,0,0, 9,0); add(1,0,0,0, 9,0); add(1,0,0,0, 9,0);
      add(1,0,0,0, 1,1);
      // faults: both directions, floor 0, floor 5, then recovery
      add(2,1,1,0, 0,1); add(2,1,1,0, 0,0);
      add(2,1,0,0, 5,1);
      add(0,1,0,0, 0,1); add(5,0,0,0, 0,0); add(5,0,0,0, 0,0);
      add(3,0,0,0, 3,1);

      rst_n = 1'b0;
      bus.floor = 3'd2; bus.moving_up = 1'b0; bus.moving_dn = 1'b0; bus.door_open = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("reset_bcd", -1, bus.BCD, 4'd0);
      check("reset_code_chg", -1, {3'b0, bus.code_chg}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // asynchronous reset in the middle of an up-alternation
      stepv(2,1,0,0, 5,1);
      stepv(2,1,0,0, 5,0);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_bcd", vec_id, bus.BCD, 4'd0);
      check("async_reset_code_chg", vec_id, {3'b0, bus.code_chg}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stepv(2,1,0,0, 5,1); stepv(2,1,0,0, 5,0); stepv(2,1,0,0, 5,0); stepv(2,1,0,0, 5,0);
      stepv(2,1,0,0, 2,1); stepv(2,1,0,0, 2,0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
